tick_scheduler: RTL and testbench

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_scheduler_pkg.sv | 22 ++
 rtl/tick_chan.sv | 87 ++++++++
 rtl/tick_scheduler.sv | 103 ++++++++++
 tb/tb_tick_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_scheduler_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tick_scheduler_pkg
// Brief   : Shared FSM state encoding and channel index constants for the
//           tick scheduler.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package tick_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_SYNC = 2'd2
  } state_t;

  // Channel roles in the default three-channel build
  localparam int c_CH_PIXEL  = 0;
  localparam int c_CH_SEG7   = 1;
  localparam int c_CH_RENDER = 2;

endpackage : tick_scheduler_pkg
`default_nettype wire

// File: rtl/tick_chan.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tick_chan
// Brief   : One tick channel: period counter, active divisor, pending divisor
//           and registered tick strobe. A pending divisor is only swapped in at
//           a period boundary so no truncated or stretched period is emitted.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module tick_chan
  import tick_scheduler_pkg::*;
#(
  parameter int            CW      = 21,
  parameter logic [CW-1:0] RST_DIV = '0
) (
  input  logic          clk,
  input  logic          clr,
  input  state_t        i_state,
  input  logic          i_zero_req,   // sync request seen while stopped
  input  logic          i_load,       // accepted divisor for this channel
  input  logic [CW-1:0] i_load_div,
  output logic          o_tick,       // raw registered strobe, gated by top
  output logic          o_pending
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_div;
  logic [CW-1:0] r_pend_div;
  logic          r_pend_v;
  logic          r_tick;

  logic          w_active;
  logic          w_wrap;
  logic          w_zero;

  // A zero divisor disables the channel; it then sits permanently at a
  // boundary so a pending divisor can still be taken up.
  assign w_active = (r_div != '0);
  assign w_wrap   = !w_active || (r_cnt == (r_div - {{(CW-1){1'b0}}, 1'b1}));
  assign w_zero   = (i_state == ST_SYNC) || ((i_state == ST_STOP) && i_zero_req);

  // Counter, divisor swap, pending capture and tick generation
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt      <= '0;
      r_div      <= RST_DIV;
      r_pend_div <= '0;
      r_pend_v   <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      // Loads only arrive when nothing is pending, so they never collide
      // with the apply paths below.
      if (i_load) begin
        r_pend_v   <= 1'b1;
        r_pend_div <= i_load_div;
      end
      if (w_zero) begin
        r_cnt <= '0;
        if (r_pend_v) begin
          r_div    <= r_pend_div;
          r_pend_v <= 1'b0;
        end
      end else if (i_state == ST_RUN) begin
        if (w_wrap) begin
          r_tick <= w_active;
          r_cnt  <= '0;
          if (r_pend_v) begin
            r_div    <= r_pend_div;
            r_pend_v <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end else if (r_pend_v) begin
        // Stopped: no period in flight, so apply at once from a clean count
        r_div    <= r_pend_div;
        r_pend_v <= 1'b0;
        r_cnt    <= '0;
      end
    end
  end

  assign o_tick    = r_tick;
  assign o_pending = r_pend_v;

endmodule : tick_chan
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tick_scheduler
// Brief   : Multi-channel clock-enable generator with STOP/RUN/SYNC control
//           and a ready/valid divisor update port. No derived clocks: every
//           consumer uses tick[i] as an enable on clk.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int NCH  = 3,
  parameter int CW   = 21,
  parameter int DIV0 = 4,
  parameter int DIV1 = 131072,
  parameter int DIV2 = 2048
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic           stop,
  input  logic           sync,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [1:0]     cfg_chan,
  input  logic [CW-1:0]  cfg_div,
  output logic [NCH-1:0] tick,
  output logic           running
);

  state_t           r_state;
  logic             r_running;
  logic [NCH-1:0]   w_tick_raw;
  logic [NCH-1:0]   w_pend;
  logic             w_accept;

  assign cfg_ready = ~|w_pend;
  assign w_accept  = cfg_valid && cfg_ready;

  // Control FSM; stop outranks start and sync
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= ST_STOP;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        ST_STOP: begin
          if (start && !stop) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_state   <= ST_STOP;
            r_running <= 1'b0;
          end else if (sync) begin
            r_state   <= ST_SYNC;
            r_running <= 1'b1;
          end
        end
        ST_SYNC: begin
          r_state   <= ST_RUN;
          r_running <= 1'b1;
        end
        default: begin
          r_state   <= ST_STOP;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // One channel per tick output; channel index beyond NCH-1 matches nothing,
  // so such updates are accepted and dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    localparam int c_RST = (i == c_CH_PIXEL)  ? DIV0 :
                           (i == c_CH_SEG7)   ? DIV1 :
                           (i == c_CH_RENDER) ? DIV2 : 0;
    logic w_load;
    assign w_load = w_accept && (int'(cfg_chan) == i);

    tick_chan #(
      .CW      (CW),
      .RST_DIV (CW'(c_RST))
    ) u_chan (
      .clk        (clk),
      .clr        (clr),
      .i_state    (r_state),
      .i_zero_req (sync),
      .i_load     (w_load),
      .i_load_div (cfg_div),
      .o_tick     (w_tick_raw[i]),
      .o_pending  (w_pend[i])
    );
  end

  // A strobe registered on the last RUN cycle must not leak into STOP/SYNC
  assign tick    = w_tick_raw & {NCH{r_state == ST_RUN}};
  assign running = r_running;

endmodule : tick_scheduler
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_tick_scheduler
// Brief   : Self-checking bench for tick_scheduler. Channel 1/2 reset divisors
//           are scaled down so every channel wraps many times in a short run.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module tb_tick_scheduler;

  localparam int NCH  = 3;
  localparam int CW   = 21;
  localparam int DIV0 = 4;
  localparam int DIV1 = 24;
  localparam int DIV2 = 11;

  logic           clk;
  logic           clr;
  logic           start;
  logic           stop;
  logic           sync;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_chan;
  logic [CW-1:0]  cfg_div;
  logic [NCH-1:0] tick;
  logic           running;

  int n_total;
  int n_bad;

  tick_scheduler #(
    .NCH  (NCH),
    .CW   (CW),
    .DIV0 (DIV0),
    .DIV1 (DIV1),
    .DIV2 (DIV2)
  ) u_dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .stop      (stop),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0=stopped, 1=running, 2=realign cycle.
  // pos[i] = cycles elapsed in the current period of channel i.
  int m_mode;
  int m_pos  [NCH];
  int m_per  [NCH];
  int m_nper [NCH];
  bit m_has  [NCH];
  logic [NCH-1:0] m_tick;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_any_pending();
    bit r = 1'b0;
    for (int i = 0; i < NCH; i++) r |= m_has[i];
    return r;
  endfunction

  task automatic m_reset();
    m_mode = 0;
    m_tick = '0;
    m_per[0] = DIV0;
    m_per[1] = DIV1;
    m_per[2] = DIV2;
    for (int i = 0; i < NCH; i++) begin
      m_pos[i]  = 0;
      m_has[i]  = 1'b0;
      m_nper[i] = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".tick"},    32'(tick),      32'(m_tick));
    chk({tag, ".running"}, 32'(running),   32'(m_mode != 0));
    chk({tag, ".ready"},   32'(cfg_ready), 32'(!m_any_pending()));
  endtask

  // One clock with the given inputs; model advanced from the same inputs.
  task automatic cyc(input bit i_st, input bit i_sp, input bit i_sy,
                     input bit i_cv, input int i_ch, input int i_dv);
    int  nxt;
    bit  acc;
    bit  boundary;
    logic [NCH-1:0] raw;
    start     = i_st;
    stop      = i_sp;
    sync      = i_sy;
    cfg_valid = i_cv;
    cfg_chan  = 2'(i_ch);
    cfg_div   = CW'(i_dv);
    #1;
    acc = i_cv && !m_any_pending();
    chk("ready_pre", 32'(cfg_ready), 32'(!m_any_pending()));

    if (m_mode == 0)      nxt = (i_st && !i_sp) ? 1 : 0;
    else if (m_mode == 1) nxt = i_sp ? 0 : (i_sy ? 2 : 1);
    else                  nxt = 1;

    raw = '0;
    for (int i = 0; i < NCH; i++) begin
      if (m_mode == 2 || (m_mode == 0 && i_sy)) begin
        m_pos[i] = 0;
        boundary = 1'b1;
      end else if (m_mode == 1) begin
        boundary = (m_per[i] == 0) || (m_pos[i] + 1 == m_per[i]);
        if (boundary) begin
          raw[i]   = (m_per[i] != 0);
          m_pos[i] = 0;
        end else begin
          m_pos[i] = m_pos[i] + 1;
        end
      end else begin
        boundary = m_has[i];
        if (m_has[i]) m_pos[i] = 0;
      end
      if (boundary && m_has[i]) begin
        m_per[i] = m_nper[i];
        m_has[i] = 1'b0;
      end
    end
    if (acc && i_ch < NCH) begin
      m_has[i_ch]  = 1'b1;
      m_nper[i_ch] = i_dv;
    end
    m_mode = nxt;
    m_tick = (m_mode == 1) ? raw : '0;

    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous clear mid-cycle, released just after the next edge
  task automatic pulse_clr();
    #2;
    clr = 1'b1;
    #1;
    chk("clr.tick",    32'(tick),      32'd0);
    chk("clr.running", 32'(running),   32'd0);
    chk("clr.ready",   32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1;
    clr = 1'b0;
    m_reset();
    check_outputs("post_clr");
  endtask

  int last_t0;
  int gap_bad;

  initial begin
    n_total   = 0;
    n_bad     = 0;
    clr       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    sync      = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    clr = 1'b0;

    // Stays stopped until start
    idle(5);
    chk("stop_hold", 32'(running), 32'd0);

    // Default periods, with an explicit gap check on channel 0
    cyc(1, 0, 0, 0, 0, 0);
    last_t0 = -1;
    gap_bad = 0;
    for (int k = 0; k < 60; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (tick[0]) begin
        if (last_t0 >= 0 && k - last_t0 != DIV0) gap_bad++;
        last_t0 = k;
      end
    end
    chk("gap_ch0_default", 32'(gap_bad), 32'd0);

    // Mid-period divisor change on channel 0; ready low until the swap
    idle(2);
    cyc(0, 0, 0, 1, 0, 10);
    chk("ready_low_after_cfg", 32'(cfg_ready), 32'd0);
    idle(45);

    // Disable channel 2, then make it continuous
    cyc(0, 0, 0, 1, 2, 0);
    idle(30);
    cyc(0, 0, 0, 1, 2, 1);
    idle(20);

    // Realign all channels
    cyc(0, 0, 0, 1, 2, 5);
    idle(3);
    cyc(0, 0, 1, 0, 0, 0);
    idle(40);

    // All three controls together: stop wins, counters frozen
    cyc(1, 1, 1, 0, 0, 0);
    chk("triple_running", 32'(running), 32'd0);
    idle(6);
    cyc(1, 0, 0, 0, 0, 0);
    idle(20);

    // Sync while stopped zeroes counters but does not start
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    idle(2);
    cyc(1, 0, 0, 0, 0, 0);
    idle(15);

    // Out-of-range channel is consumed and dropped
    cyc(0, 0, 0, 1, 3, 2);
    chk("chan3_ready", 32'(cfg_ready), 32'd1);
    idle(10);

    // Clear with an update pending returns to defaults
    cyc(0, 0, 0, 1, 1, 3);
    pulse_clr();
    idle(3);
    cyc(1, 0, 0, 0, 0, 0);
    idle(60);

    // Randomized phase
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        pulse_clr();
      end else begin
        cyc($urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 15,
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 12)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_tick_scheduler
`default_nettype wire
